// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared types and constants for the instruction-fetch front end.
//   fetch_state_t    : fetch FSM states (IDLE, REQ, HOLD, DROP)
//   NOP_INSTR        : canonical NOP (addi x0,x0,0) presented for empty IF/ID slots
//   RESET_PC_DEFAULT : default first fetch address (4-byte aligned)
// -----------------------------------------------------------------------------
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register with flush, stall and bubble injection.
// Priority each clock: flush (bubble) > stall (hold) > load (capture) > bubble.
// A bubble is NOP_INSTR with valid=0 and zeroed PC fields.
// Ports:
//   clk_i, rst_n_i   clock, asynchronous active-low reset
//   flush_i          force a bubble into the slot
//   stall_i          hold the current slot contents
//   load_i           capture instr_i / pc_i as a valid instruction
//   instr_i, pc_i    incoming instruction and its address
//   instr_o, pc_o    registered instruction and address
//   pc_plus4_o       registered pc_o + 4 (modulo 2^DATA_WIDTH)
//   valid_o          slot holds a real instruction
// -----------------------------------------------------------------------------
module if_id_reg
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  flush_i,
  input  logic                  stall_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] instr_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] pc_plus4_o,
  output logic                  valid_o
);

  localparam logic [DATA_WIDTH-1:0] NOP  = DATA_WIDTH'(NOP_INSTR);
  localparam logic [DATA_WIDTH-1:0] FOUR = DATA_WIDTH'(4);
  localparam logic [DATA_WIDTH-1:0] ZERO = '0;

  logic bubble;

  // An unstalled slot with nothing to load still has to be emptied.
  assign bubble = flush_i || (!stall_i && !load_i);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      instr_o    <= NOP;
      pc_o       <= ZERO;
      pc_plus4_o <= ZERO;
      valid_o    <= 1'b0;
    end else if (bubble) begin
      instr_o    <= NOP;
      pc_o       <= ZERO;
      pc_plus4_o <= ZERO;
      valid_o    <= 1'b0;
    end else if (!stall_i) begin
      instr_o    <= instr_i;
      pc_o       <= pc_i;
      pc_plus4_o <= pc_i + FOUR;
      valid_o    <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage plus IF/ID register. Owns PCF, runs a req/ready
// handshake with instruction memory, parks a response that arrives while the
// pipeline is stalled, and throws away a fetch that is still in flight when a
// redirect arrives. Empty IF/ID slots present NOP (addi x0,x0,0).
//
// Parameters:
//   DATA_WIDTH  instruction/address width
//   RESET_PC    first fetch address (4-byte aligned)
// Ports:
//   clk_i, rst_n_i          clock, asynchronous active-low reset
//   PCSrc_i, PCTarget_i     redirect request and target (bits [1:0] ignored)
//   StallF_i                freeze PCF and IF/ID
//   FlushD_i                load a bubble into IF/ID (wins over stall/load)
//   imem_req_o, imem_addr_o fetch request / address (address = PCF)
//   imem_rdata_i            instruction, valid with imem_ready_i
//   imem_ready_i            completes the outstanding request
//   InstrD_o, PCD_o         decode-stage instruction and its PC
//   PCPlus4D_o              PCD_o + 4
//   ValidD_o                IF/ID slot holds a real instruction
// Optional feature (macro FETCH_PERF_CNT_EN):
//   FetchCount_o            counts valid IF/ID loads, wraps at 2^32
//   BubbleCount_o           counts bubble IF/ID loads (flush included), wraps
// -----------------------------------------------------------------------------
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  PCSrc_i,
  input  logic [DATA_WIDTH-1:0] PCTarget_i,
  input  logic                  StallF_i,
  input  logic                  FlushD_i,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  input  logic                  imem_ready_i,
  output logic [DATA_WIDTH-1:0] InstrD_o,
  output logic [DATA_WIDTH-1:0] PCD_o,
  output logic [DATA_WIDTH-1:0] PCPlus4D_o,
  output logic                  ValidD_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           FetchCount_o,
  output logic [31:0]           BubbleCount_o
`endif
);

  localparam logic [DATA_WIDTH-1:0] FOUR = DATA_WIDTH'(4);

  fetch_state_t          state_q;
  logic [DATA_WIDTH-1:0] pcf_q;
  logic [DATA_WIDTH-1:0] pcf_plus4;
  logic [DATA_WIDTH-1:0] target_al;
  logic [DATA_WIDTH-1:0] hold_instr_q;
  logic [DATA_WIDTH-1:0] drop_target_q;
  logic                  ifid_load;
  logic [DATA_WIDTH-1:0] ifid_instr;
  logic                  unused_target_lsb;

  // Redirect targets are forced word-aligned; the low bits are dropped.
  assign target_al         = {PCTarget_i[DATA_WIDTH-1:2], 2'b00};
  assign unused_target_lsb = ^PCTarget_i[1:0];
  assign pcf_plus4         = pcf_q + FOUR;

  // DROP keeps the request up: the old fetch must still be completed.
  assign imem_req_o  = (state_q == REQ) || (state_q == DROP);
  assign imem_addr_o = pcf_q;

  // What IF/ID would capture if neither stalled nor flushed. In REQ with a
  // stall the same response goes into the hold register instead.
  always_comb begin
    ifid_load  = 1'b0;
    ifid_instr = imem_rdata_i;
    case (state_q)
      REQ:  ifid_load = imem_ready_i && !PCSrc_i;
      HOLD: begin
        ifid_load  = !PCSrc_i;
        ifid_instr = hold_instr_q;
      end
      default: ifid_load = 1'b0;
    endcase
  end

  // Fetch FSM and PCF
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      pcf_q   <= RESET_PC;
    end else begin
      case (state_q)
        IDLE: state_q <= REQ;
        REQ: begin
          if (PCSrc_i) begin
            if (imem_ready_i) begin
              pcf_q <= target_al;
            end else begin
              state_q <= DROP;
            end
          end else if (imem_ready_i) begin
            if (StallF_i) begin
              state_q <= HOLD;
            end else begin
              pcf_q <= pcf_plus4;
            end
          end
        end
        HOLD: begin
          // A redirect beats a stall release: the parked instruction is stale.
          if (PCSrc_i) begin
            pcf_q   <= target_al;
            state_q <= REQ;
          end else if (!StallF_i) begin
            pcf_q   <= pcf_plus4;
            state_q <= REQ;
          end
        end
        DROP: begin
          // A redirect arriving on the completing cycle is the newest target.
          if (imem_ready_i) begin
            pcf_q   <= PCSrc_i ? target_al : drop_target_q;
            state_q <= REQ;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Parked response and pending redirect target; qualified by the FSM state,
  // so they need no reset.
  always_ff @(posedge clk_i) begin
    if (state_q == REQ && imem_ready_i && !PCSrc_i && StallF_i) begin
      hold_instr_q <= imem_rdata_i;
    end
    if (PCSrc_i && (state_q == DROP || (state_q == REQ && !imem_ready_i))) begin
      drop_target_q <= target_al;
    end
  end

  // IF/ID boundary
  if_id_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_if_id_reg (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .flush_i    (FlushD_i),
    .stall_i    (StallF_i),
    .load_i     (ifid_load),
    .instr_i    (ifid_instr),
    .pc_i       (pcf_q),
    .instr_o    (InstrD_o),
    .pc_o       (PCD_o),
    .pc_plus4_o (PCPlus4D_o),
    .valid_o    (ValidD_o)
  );

`ifdef FETCH_PERF_CNT_EN
  logic valid_load;
  logic bubble_load;

  // Mirrors the IF/ID priority: flush > stall > load > bubble.
  assign valid_load  = !FlushD_i && !StallF_i && ifid_load;
  assign bubble_load = FlushD_i || (!StallF_i && !ifid_load);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      FetchCount_o  <= 32'd0;
      BubbleCount_o <= 32'd0;
    end else begin
      if (valid_load)  FetchCount_o  <= FetchCount_o + 32'd1;
      if (bubble_load) BubbleCount_o <= BubbleCount_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pcsrc = 1'b0;
  logic [31:0] tgt = 32'h0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        ready = 1'b0;
  logic [31:0] salt = 32'h0;
  logic        chk_en = 1'b0;

  logic        req;
  logic [31:0] addr, rdata, instr, pcd, pcp4;
  logic        valid;

  logic        w_req, w_valid;
  logic [31:0] w_addr, w_instr, w_pcd, w_pcp4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Memory returns a salted copy of the address so instr and PC differ.
  assign rdata = addr ^ salt;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fcnt, bcnt, w_fcnt, w_bcnt;
`endif

  fetch_stage dut (
    .clk_i(clk), .rst_n_i(rst_n), .PCSrc_i(pcsrc), .PCTarget_i(tgt),
    .StallF_i(stall), .FlushD_i(flush), .imem_req_o(req), .imem_addr_o(addr),
    .imem_rdata_i(rdata), .imem_ready_i(ready), .InstrD_o(instr), .PCD_o(pcd),
    .PCPlus4D_o(pcp4), .ValidD_o(valid)
`ifdef FETCH_PERF_CNT_EN
    , .FetchCount_o(fcnt), .BubbleCount_o(bcnt)
`endif
  );

  fetch_stage #(.DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk_i(clk), .rst_n_i(rst_n), .PCSrc_i(1'b0), .PCTarget_i(32'h0),
    .StallF_i(1'b0), .FlushD_i(1'b0), .imem_req_o(w_req), .imem_addr_o(w_addr),
    .imem_rdata_i(w_addr), .imem_ready_i(1'b1), .InstrD_o(w_instr), .PCD_o(w_pcd),
    .PCPlus4D_o(w_pcp4), .ValidD_o(w_valid)
`ifdef FETCH_PERF_CNT_EN
    , .FetchCount_o(w_fcnt), .BubbleCount_o(w_bcnt)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Behavioural model: tracks whether the front end has started, whether a
  // response is parked, whether an in-flight fetch is being thrown away, and
  // what the decode slot must contain.
  bit          m_started, m_parked, m_discard;
  logic [31:0] m_pc, m_park, m_tgt;
  logic [31:0] e_instr, e_pcd, e_pcp4;
  bit          e_valid;
  int unsigned e_fc, e_bc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_started = 0; m_parked = 0; m_discard = 0;
      m_pc = 32'h0; m_park = 32'h0; m_tgt = 32'h0;
      e_instr = 32'h13; e_pcd = 0; e_pcp4 = 0; e_valid = 0;
      e_fc = 0; e_bc = 0;
    end else begin
      bit          got;
      logic [31:0] gi, gp, t;
      got = 0; gi = 0; gp = 0;
      t = tgt & 32'hFFFF_FFFC;
      if (!m_started) begin
        m_started = 1;
      end else if (m_parked) begin
        if (pcsrc) begin
          m_parked = 0; m_pc = t;
        end else if (!stall) begin
          got = 1; gi = m_park; gp = m_pc; m_parked = 0; m_pc = m_pc + 4;
        end
      end else if (m_discard) begin
        if (pcsrc) m_tgt = t;
        if (ready) begin m_discard = 0; m_pc = m_tgt; end
      end else begin
        if (pcsrc) begin
          if (ready) m_pc = t;
          else begin m_discard = 1; m_tgt = t; end
        end else if (ready) begin
          if (stall) begin m_parked = 1; m_park = m_pc ^ salt; end
          else begin got = 1; gi = m_pc ^ salt; gp = m_pc; m_pc = m_pc + 4; end
        end
      end
      if (flush || (!stall && !got)) begin
        e_instr = 32'h13; e_pcd = 0; e_pcp4 = 0; e_valid = 0; e_bc++;
      end else if (!stall) begin
        e_instr = gi; e_pcd = gp; e_pcp4 = gp + 4; e_valid = 1; e_fc++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req", {31'b0, req}, {31'b0, m_started && !m_parked});
      chk("addr", addr, m_pc);
      chk("valid", {31'b0, valid}, {31'b0, e_valid});
      chk("instr", instr, e_instr);
      if (e_valid) begin
        chk("pcd", pcd, e_pcd);
        chk("pcp4", pcp4, e_pcp4);
      end
`ifdef FETCH_PERF_CNT_EN
      chk("fetch_cnt", fcnt, e_fc);
      chk("bubble_cnt", bcnt, e_bc);
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    // Reset values
    chk_en = 1'b1;
    cyc(); cyc();
    chk("rst_req", {31'b0, req}, 32'd0);
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_pcd", pcd, 32'h0);
    chk("rst_pcp4", pcp4, 32'h0);
    chk("rst_addr", addr, 32'h0);
    chk("w_rst_addr", w_addr, 32'hFFFF_FFFC);

    // Streaming fetch, ready every cycle
    rst_n = 1'b1; ready = 1'b1;
    cyc();
    chk("t1_addr0", addr, 32'h0);
    chk("t1_req", {31'b0, req}, 32'd1);
    chk("w_addr0", w_addr, 32'hFFFF_FFFC);
    cyc();
    chk("t1_addr4", addr, 32'h4);
    chk("t1_instr0", instr, 32'h0);
    chk("t1_valid", {31'b0, valid}, 32'd1);
    chk("w_wrap_addr", w_addr, 32'h0);
    chk("w_wrap_pcd", w_pcd, 32'hFFFF_FFFC);
    chk("w_wrap_pcp4", w_pcp4, 32'h0);
    cyc();
    chk("t1_addr8", addr, 32'h8);
    chk("t1_instr4", instr, 32'h4);
    chk("t1_pcp4", pcp4, 32'h8);

    // ready low for 3 cycles at address 8
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t2_addr", addr, 32'h8);
      chk("t2_req", {31'b0, req}, 32'd1);
      chk("t2_valid", {31'b0, valid}, 32'd0);
      chk("t2_nop", instr, 32'h13);
    end
    ready = 1'b1;
    cyc();
    chk("t2_instr8", instr, 32'h8);
    cyc();
    chk("t2_addr10", addr, 32'h10);

    // Stall when the response for 0x10 arrives
    stall = 1'b1;
    cyc();
    chk("t3_req0", {31'b0, req}, 32'd0);
    chk("t3_addr", addr, 32'h10);
    ready = 1'b0;
    cyc();
    chk("t3_req0b", {31'b0, req}, 32'd0);
    chk("t3_held", instr, 32'hC);
    stall = 1'b0;
    cyc();
    chk("t3_instr", instr, 32'h10);
    chk("t3_valid", {31'b0, valid}, 32'd1);
    chk("t3_addr14", addr, 32'h14);

    // Redirect while a request is pending; response two cycles later
    pcsrc = 1'b1; tgt = 32'h100; flush = 1'b1;
    cyc();
    chk("t4_addr_old", addr, 32'h14);
    chk("t4_req", {31'b0, req}, 32'd1);
    pcsrc = 1'b0; flush = 1'b0;
    cyc();
    chk("t4_addr_old2", addr, 32'h14);
    ready = 1'b1;
    cyc();
    chk("t4_addr_tgt", addr, 32'h100);
    chk("t4_valid", {31'b0, valid}, 32'd0);
    salt = 32'h5A5A_0000;
    cyc();
    chk("t4_instr", instr, 32'h5A5A_0100);
    chk("t4_pcd", pcd, 32'h100);
    chk("t4_pcp4", pcp4, 32'h104);

    // Flush beats stall
    stall = 1'b1; flush = 1'b1; ready = 1'b0;
    cyc();
    chk("t5_valid", {31'b0, valid}, 32'd0);
    chk("t5_nop", instr, 32'h13);
    flush = 1'b0;
    cyc();
    stall = 1'b0;

    // Redirect coinciding with ready; target low bits masked
    pcsrc = 1'b1; tgt = 32'h203; ready = 1'b1;
    cyc();
    chk("t6_addr", addr, 32'h200);
    pcsrc = 1'b0;

    // Redirect while a response is parked
    stall = 1'b1;
    cyc();
    chk("t7_req0", {31'b0, req}, 32'd0);
    pcsrc = 1'b1; tgt = 32'h300; ready = 1'b0;
    cyc();
    chk("t7_addr", addr, 32'h300);
    chk("t7_req1", {31'b0, req}, 32'd1);
    pcsrc = 1'b0; stall = 1'b0;

    // Second redirect while discarding overwrites the first
    pcsrc = 1'b1; tgt = 32'h400;
    cyc();
    tgt = 32'h500;
    cyc();
    chk("t8_addr_old", addr, 32'h300);
    pcsrc = 1'b0; ready = 1'b1;
    cyc();
    chk("t8_addr", addr, 32'h500);
    cyc();
    chk("t8_instr", instr, 32'h5A5A_0500);

    // Reset in the middle of a discard
    ready = 1'b0; pcsrc = 1'b1; tgt = 32'h600;
    cyc();
    pcsrc = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t9_req", {31'b0, req}, 32'd0);
    chk("t9_addr", addr, 32'h0);
    chk("t9_valid", {31'b0, valid}, 32'd0);
    chk("t9_instr", instr, 32'h13);
    cyc();
    rst_n = 1'b1; ready = 1'b1; salt = 32'h0;
    cyc();
    chk("t9_first", addr, 32'h0);
    cyc();
    chk("t9_instr0", instr, 32'h0);
    chk("t9_valid1", {31'b0, valid}, 32'd1);

    // Mixed pattern table, checked cycle by cycle against the model
    for (int i = 0; i < 60; i++) begin
      ready = (i % 3) != 1;
      stall = (i % 5) == 2;
      pcsrc = (i % 11) == 5;
      flush = ((i % 7) == 3) || pcsrc;
      tgt   = 32'h800 + i * 16 + 1;
      salt  = 32'h1234_0000 ^ i;
      cyc();
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
